// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, multi-cycle multiply freeze, taken-branch squash.
// Optional performance counters (StallCycles, FlushCount) are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_controller #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       IDEX_MemRead,
  input  logic [4:0] IDEX_Rt,
  input  logic [4:0] IFID_Rs,
  input  logic [4:0] IFID_Rt,
  input  logic       IFID_UsesRt,
  input  logic       Branch_Taken,
  input  logic       Mul_Start,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IDEXWrite,
  output logic       Hazard,
  output logic       Flush,
  output logic       EXBubble,
  output logic       Mul_Done,
  output logic       Busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
`endif
);

  typedef enum logic {RUN, MUL_BUSY} state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cntNext;
  logic               w_loadUse;

  assign w_loadUse = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                     ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEXWrite   = 1'b1;
    Hazard      = 1'b0;
    Flush       = 1'b0;
    EXBubble    = 1'b0;
    Mul_Done    = 1'b0;
    Busy        = 1'b0;
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      RUN: begin
        if (Branch_Taken) begin
          Flush = 1'b1;
        end else if (Mul_Start) begin
          // A load-use seen alongside the multiply is simply re-detected once the freeze ends.
          PCWrite     = 1'b0;
          IFIDWrite   = 1'b0;
          IDEXWrite   = 1'b0;
          EXBubble    = 1'b1;
          w_stateNext = MUL_BUSY;
          w_cntNext   = CNT_W'(MUL_LATENCY - 1);
        end else if (w_loadUse) begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          Hazard    = 1'b1;
        end
      end
      MUL_BUSY: begin
        Busy = 1'b1;
        if (r_cnt != '0) begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          IDEXWrite = 1'b0;
          EXBubble  = 1'b1;
          w_cntNext = r_cnt - CNT_W'(1);
        end else begin
          Mul_Done    = 1'b1;
          w_stateNext = RUN;
        end
      end
      default: w_stateNext = RUN;
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stallCycles;
  logic [31:0] r_flushCount;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_stallCycles <= '0;
      r_flushCount  <= '0;
    end else begin
      if (!PCWrite && (r_stallCycles != 32'hFFFF_FFFF))
        r_stallCycles <= r_stallCycles + 32'd1;
      if (Flush && (r_flushCount != 32'hFFFF_FFFF))
        r_flushCount <= r_flushCount + 32'd1;
    end
  end

  assign StallCycles = r_stallCycles;
  assign FlushCount  = r_flushCount;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (default MUL_LATENCY=4); perf counters checked when HAZARD_PERF_CNT_EN is defined.
module tb_pipeline_hazard_controller;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       IDEX_MemRead, IFID_UsesRt, Branch_Taken, Mul_Start;
  logic [4:0] IDEX_Rt, IFID_Rs, IFID_Rt;
  logic       PCWrite, IFIDWrite, IDEXWrite, Hazard, Flush, EXBubble, Mul_Done, Busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCycles, FlushCount;
`endif

  int vectors = 0;
  int miscompares = 0;

  // {PCWrite,IFIDWrite,IDEXWrite,Hazard,Flush,EXBubble,Mul_Done,Busy}
  localparam logic [7:0] PASS   = 8'b111_00000;
  localparam logic [7:0] LU     = 8'b001_10000;
  localparam logic [7:0] FLUSH  = 8'b111_01000;
  localparam logic [7:0] MSTART = 8'b000_00100;
  localparam logic [7:0] MBUSY  = 8'b000_00101;
  localparam logic [7:0] MDONE  = 8'b111_00011;

  pipeline_hazard_controller dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .Branch_Taken(Branch_Taken), .Mul_Start(Mul_Start),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
    .Hazard(Hazard), .Flush(Flush), .EXBubble(EXBubble),
    .Mul_Done(Mul_Done), .Busy(Busy)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCycles(StallCycles), .FlushCount(FlushCount)
`endif
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic mr, input logic [4:0] exRt, input logic [4:0] rs,
                               input logic [4:0] rt, input logic uses, input logic br,
                               input logic mul);
    IDEX_MemRead = mr;
    IDEX_Rt      = exRt;
    IFID_Rs      = rs;
    IFID_Rt      = rt;
    IFID_UsesRt  = uses;
    Branch_Taken = br;
    Mul_Start    = mul;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expected);
    logic [7:0] observed;
    observed = {PCWrite, IFIDWrite, IDEXWrite, Hazard, Flush, EXBubble, Mul_Done, Busy};
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Apply inputs 1 ns after a rising edge and check 2 ns later, well clear of the next edge.
  task automatic step(input logic mr, input logic [4:0] exRt, input logic [4:0] rs,
                      input logic [4:0] rt, input logic uses, input logic br, input logic mul,
                      input string tag, input logic [7:0] expected);
    @(posedge Clk);
    #1;
    applyStimulus(mr, exRt, rs, rt, uses, br, mul);
    #2;
    checkOutput(tag, expected);
  endtask

  task automatic doReset();
    @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("reset_idle", PASS);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    Rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("reset_initial", PASS);
    @(negedge Clk);
    Rst_n = 1'b1;

    step(1, 5'd8, 5'd8, 5'd0, 0, 0, 0, "lu_rs", LU);
    step(0, 5'd8, 5'd8, 5'd0, 0, 0, 0, "lu_clear", PASS);
    step(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, "lu_zero_reg", PASS);
    step(1, 5'd9, 5'd3, 5'd9, 0, 0, 0, "lu_rt_unused", PASS);
    step(1, 5'd9, 5'd3, 5'd9, 1, 0, 0, "lu_rt_used", LU);
    step(0, 5'd9, 5'd9, 5'd9, 1, 0, 0, "no_load", PASS);

    step(1, 5'd8, 5'd8, 5'd0, 0, 1, 0, "branch_over_lu", FLUSH);
    step(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, "branch_over_mul", FLUSH);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, "after_branch_mul", PASS);

    // Multiply held high: stall cycles 0-3, done in 4, immediate restart in 5.
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, "mul_c0", MSTART);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, "mul_c1", MBUSY);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, "mul_c2", MBUSY);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, "mul_c3", MBUSY);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, "mul_c4_done", MDONE);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, "mul_b2b_start", MSTART);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, "mul_b2b_cnt3", MBUSY);
    step(1, 5'd8, 5'd8, 5'd0, 0, 1, 1, "mul_ignore_br_cnt2", MBUSY);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, "mul_b2b_cnt1", MBUSY);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, "mul_b2b_done", MDONE);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, "mul_b2b_run", PASS);

    // Load-use coincident with a multiply start waits, then is seen again after the done cycle.
    step(1, 5'd7, 5'd7, 5'd0, 0, 0, 1, "mul_defers_lu", MSTART);
    step(1, 5'd7, 5'd7, 5'd0, 0, 0, 0, "defer_cnt3", MBUSY);
    step(1, 5'd7, 5'd7, 5'd0, 0, 0, 0, "defer_cnt2", MBUSY);
    step(1, 5'd7, 5'd7, 5'd0, 0, 0, 0, "defer_cnt1", MBUSY);
    step(1, 5'd7, 5'd7, 5'd0, 0, 0, 0, "defer_done", MDONE);
    step(1, 5'd7, 5'd7, 5'd0, 0, 0, 0, "defer_lu_after", LU);

    // Asynchronous reset while cnt=2, observed before the next edge.
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, "rst_mul_start", MSTART);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, "rst_mul_cnt3", MBUSY);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, "rst_mul_cnt2", MBUSY);
    #1;
    Rst_n = 1'b0;
    #1;
    checkOutput("async_reset_mid_mul", PASS);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, "post_reset_idle", PASS);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, "post_reset_idle2", PASS);

`ifdef HAZARD_PERF_CNT_EN
    doReset();
    checkValue("stall_cnt_reset", StallCycles, 32'd0);
    checkValue("flush_cnt_reset", FlushCount, 32'd0);
    step(1, 5'd8, 5'd8, 5'd0, 0, 0, 0, "perf_lu", LU);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, "perf_mul_c0", MSTART);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, "perf_mul_c1", MBUSY);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, "perf_mul_c2", MBUSY);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, "perf_mul_c3", MBUSY);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, "perf_mul_done", MDONE);
    step(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, "perf_br1", FLUSH);
    step(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, "perf_br2", FLUSH);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, "perf_idle", PASS);
    checkValue("stall_cycles", StallCycles, 32'd5);
    checkValue("flush_count", FlushCount, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Detects load-use hazards from the IF/ID and ID/EX fields.
- Freezes the front end for a fixed number of cycles while a multi-cycle multiply occupies EX.
- Squashes wrong-path instructions on a taken branch.
- Hazard and Flush drive the Hazard/Branch bubble inputs of the ID/EX control register.
- PCWrite, IFIDWrite and IDEXWrite gate the PC and pipeline registers.

Parameters:
MUL_LATENCY, 4, number of stall cycles a multiply holds EX; legal range 1..15
CNT_W, 4, width of the multiply cycle counter; must satisfy 2^CNT_W > MUL_LATENCY

Ports:
Clk  input  1  pipeline clock, rising edge
Rst_n  input  1  asynchronous active-low reset
IDEX_MemRead  input  1  instruction in EX is a load
IDEX_Rt  input  5  load destination register in EX
IFID_Rs  input  5  source register rs of instruction in ID
IFID_Rt  input  5  source register rt of instruction in ID
IFID_UsesRt  input  1  instruction in ID reads rt
Branch_Taken  input  1  branch/jump resolved taken in EX this cycle
Mul_Start  input  1  instruction in EX is a multi-cycle multiply
PCWrite  output  1  PC update enable
IFIDWrite  output  1  IF/ID register enable
IDEXWrite  output  1  ID/EX register enable
Hazard  output  1  insert bubble into ID/EX control
Flush  output  1  squash IF/ID and ID/EX contents (taken branch)
EXBubble  output  1  insert bubble into EX/MEM
Mul_Done  output  1  multiply finishes this cycle; EX result is valid
Busy  output  1  FSM is in MUL_BUSY

Behaviour:
- Registered state: FSM {RUN, MUL_BUSY} and cnt[CNT_W-1:0]. All outputs are combinational from state, cnt and inputs (Mealy); detection has zero-cycle latency.
- Reset: Rst_n low sets state=RUN and cnt=0 immediately, including mid-multiply. With inputs idle, outputs are PCWrite=IFIDWrite=IDEXWrite=1 and all others 0.
- LU (load-use) = IDEX_MemRead && IDEX_Rt!=0 && (IDEX_Rt==IFID_Rs || (IFID_UsesRt && IDEX_Rt==IFID_Rt)).
- RUN outputs, priority order:
  1. Branch_Taken: Flush=1; PCWrite=IFIDWrite=IDEXWrite=1; Hazard=0, even when LU is true (wrong-path instruction). Mul_Start is not evaluated.
  2. Mul_Start: PCWrite=IFIDWrite=IDEXWrite=0; EXBubble=1; Hazard=0. Next state MUL_BUSY with cnt=MUL_LATENCY-1. A simultaneous LU is deferred and re-evaluated after the multiply.
  3. LU: PCWrite=IFIDWrite=0; Hazard=1; IDEXWrite=1. Exactly one bubble is inserted; the condition clears naturally next cycle.
  4. Otherwise: pass-through, with PCWrite=IFIDWrite=IDEXWrite=1 and all others 0.
- MUL_BUSY:
  - cnt!=0: stall outputs as RUN case 2, Busy=1; cnt decrements. Mul_Start, LU and Branch_Taken are ignored.
  - cnt==0: Mul_Done=1, Busy=1, EXBubble=0, PCWrite=IFIDWrite=IDEXWrite=1; next state RUN.
- A multiply therefore stalls exactly MUL_LATENCY cycles (start cycle included), followed by one Mul_Done cycle.
- MUL_LATENCY=1: start cycle stalls, the next cycle is Mul_Done.
- Back-to-back multiplies: a new Mul_Start in the first RUN cycle after Mul_Done restarts the sequence.
- cnt never wraps; decrement occurs only while cnt!=0.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds output ports StallCycles[31:0] and FlushCount[31:0], both reset to 0 by Rst_n.
  - StallCycles increments on every cycle with PCWrite=0.
  - FlushCount increments on every cycle with Flush=1.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Load-use: IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 for one cycle -> that cycle Hazard=1, PCWrite=0, IFIDWrite=0; next cycle (MemRead=0) all pass-through.
- Zero register and rt-unused cases:
  - IDEX_Rt=0, IFID_Rs=0, MemRead=1 -> no stall.
  - IDEX_Rt=9, IFID_Rt=9, IFID_UsesRt=0 -> no stall.
  - Same with IFID_UsesRt=1 -> Hazard=1.
- Multiply, MUL_LATENCY=4: Mul_Start held high from cycle 0 -> PCWrite=0 and EXBubble=1 in cycles 0-3; Busy=1 in cycles 1-4; Mul_Done=1 only in cycle 4; RUN in cycle 5.
- Branch priority: Branch_Taken=1 with LU true -> Flush=1, Hazard=0, PCWrite=1. Branch_Taken pulse during MUL_BUSY (cnt=2) -> ignored, Flush=0.
- Reset mid-multiply: assert Rst_n=0 asynchronously at cnt=2 -> Busy=0 and PCWrite=1 immediately, without a clock edge; after release, Mul_Start=0 gives pass-through.
- HAZARD_PERF_CNT_EN defined: one load-use stall + one 4-cycle multiply + two taken branches -> StallCycles=5, FlushCount=2.
